// File: rtl/fc_pipeline_scheduler.sv
// Frame-level start scheduler for a chain of FC layers separated by FIFOs.
// A layer starts only when a whole input vector is buffered and a whole output vector fits.
module fc_pipeline_scheduler #(
  parameter int                        NUM_LAYERS      = 3,
  parameter int                        LVL_WIDTH       = 10,
  parameter logic [NUM_LAYERS*12-1:0]  IN_SIZES        = {12'd50, 12'd100, 12'd6},
  parameter logic [NUM_LAYERS*12-1:0]  OUT_SIZES       = {12'd3, 12'd50, 12'd100},
  parameter int                        FRAME_CNT_WIDTH = 16,
  parameter int                        TIMEOUT_CYCLES  = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            network_enable,
  input  logic                            pipeline_reset,
  input  logic [NUM_LAYERS-1:0]           layer_busy,
  input  logic [NUM_LAYERS-1:0]           layer_done,
  input  logic [NUM_LAYERS*LVL_WIDTH-1:0] in_level,
  input  logic [NUM_LAYERS*LVL_WIDTH-1:0] out_free,
  output logic [NUM_LAYERS-1:0]           layer_start,
  output logic                            pipeline_busy,
  output logic                            pipeline_stalled,
  output logic                            pipeline_ready,
  output logic [FRAME_CNT_WIDTH-1:0]      frames_in,
  output logic [FRAME_CNT_WIDTH-1:0]      frames_out,
  output logic [NUM_LAYERS-1:0]           layer_timeout,
  output logic                            protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam int             WD_W     = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [NUM_LAYERS-1:0] start_d;
  logic [NUM_LAYERS-1:0] done_acc;
  logic [NUM_LAYERS-1:0] perr_v;
  logic [NUM_LAYERS-1:0] idle_v;
  logic [NUM_LAYERS-1:0] stall_v;
  logic [NUM_LAYERS-1:0] lvl_zero_v;

  // layer_busy is informational; scheduling relies on the done pulses alone.
  logic unused_layer_busy;
  assign unused_layer_busy = ^layer_busy;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    localparam logic [LVL_WIDTH+11:0] IN_EXT  = {{LVL_WIDTH{1'b0}}, IN_SIZES[i*12 +: 12]};
    localparam logic [LVL_WIDTH+11:0] OUT_EXT = {{LVL_WIDTH{1'b0}}, OUT_SIZES[i*12 +: 12]};
    localparam logic [LVL_WIDTH-1:0]  IN_SZ   = IN_EXT[LVL_WIDTH-1:0];
    localparam logic [LVL_WIDTH-1:0]  OUT_SZ  = OUT_EXT[LVL_WIDTH-1:0];

    logic [LVL_WIDTH-1:0] lvl;
    logic [LVL_WIDTH-1:0] free;
    logic                 in_ok;
    logic                 out_ok;
    state_t               state_q;
    state_t               state_d;
    logic                 start_q;
    logic                 timeout_q;
    logic [WD_W-1:0]      wd_cnt;
    logic [WD_W-1:0]      wd_inc;

    assign lvl    = in_level[i*LVL_WIDTH +: LVL_WIDTH];
    assign free   = out_free[i*LVL_WIDTH +: LVL_WIDTH];
    assign in_ok  = (lvl >= IN_SZ);
    assign out_ok = (free >= OUT_SZ);
    assign wd_inc = wd_cnt + WD_W'(1);

    // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE:  if (network_enable && in_ok && out_ok) state_d = S_START;
        S_START: state_d = layer_done[i] ? S_IDLE : S_RUN;
        S_RUN:   if (layer_done[i]) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (pipeline_reset) state_d = S_IDLE;
    end

    assign start_d[i]    = (state_q == S_IDLE) && (state_d == S_START);
    assign done_acc[i]   = (state_q != S_IDLE) && layer_done[i] && !pipeline_reset;
    assign perr_v[i]     = (state_q == S_IDLE) && layer_done[i] && !pipeline_reset;
    assign idle_v[i]     = (state_q == S_IDLE);
    assign stall_v[i]    = (state_q == S_IDLE) && in_ok && !out_ok;
    assign lvl_zero_v[i] = (i == 0) ? 1'b1 : (lvl == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= S_IDLE;
        start_q   <= 1'b0;
        wd_cnt    <= '0;
        timeout_q <= 1'b0;
      end else if (pipeline_reset) begin
        state_q   <= S_IDLE;
        start_q   <= 1'b0;
        wd_cnt    <= '0;
        timeout_q <= 1'b0;
      end else begin
        state_q <= state_d;
        start_q <= start_d[i];
        if (start_d[i]) begin
          wd_cnt <= '0;
        end else if (WD_EN && (state_q != S_IDLE) && (wd_cnt != WD_LIMIT)) begin
          // Saturates at the limit; the layer keeps running until its done arrives.
          wd_cnt <= wd_inc;
          if (wd_inc == WD_LIMIT) timeout_q <= 1'b1;
        end
      end
    end

    assign layer_start[i]   = start_q;
    assign layer_timeout[i] = timeout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_in    <= '0;
      frames_out   <= '0;
      protocol_err <= 1'b0;
    end else if (pipeline_reset) begin
      frames_in    <= '0;
      frames_out   <= '0;
      protocol_err <= 1'b0;
    end else begin
      frames_in    <= frames_in + FRAME_CNT_WIDTH'(start_d[0]);
      frames_out   <= frames_out + FRAME_CNT_WIDTH'(done_acc[NUM_LAYERS-1]);
      protocol_err <= protocol_err | (|perr_v);
    end
  end

  assign pipeline_busy    = ~&idle_v;
  assign pipeline_stalled = |stall_v;
  assign pipeline_ready   = network_enable & (&idle_v) & (&lvl_zero_v);

endmodule

// File: tb/tb_fc_pipeline_scheduler.sv
// Directed bench for fc_pipeline_scheduler: vector table plus hand sequences for
// chain flow, counter wrap, watchdog, protocol error and both reset styles.
module tb_fc_pipeline_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        network_enable;
  logic        pipeline_reset;
  logic [2:0]  layer_busy;
  logic [2:0]  layer_done;
  logic [29:0] in_level;
  logic [29:0] out_free;
  logic [2:0]  layer_start;
  logic        pipeline_busy;
  logic        pipeline_stalled;
  logic        pipeline_ready;
  logic [1:0]  frames_in;
  logic [1:0]  frames_out;
  logic [2:0]  layer_timeout;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  int in_sz[3]  = '{6, 100, 50};
  int out_sz[3] = '{100, 50, 3};

  fc_pipeline_scheduler #(
    .NUM_LAYERS      (3),
    .LVL_WIDTH       (10),
    .IN_SIZES        ({12'd50, 12'd100, 12'd6}),
    .OUT_SIZES       ({12'd3, 12'd50, 12'd100}),
    .FRAME_CNT_WIDTH (2),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .network_enable   (network_enable),
    .pipeline_reset   (pipeline_reset),
    .layer_busy       (layer_busy),
    .layer_done       (layer_done),
    .in_level         (in_level),
    .out_free         (out_free),
    .layer_start      (layer_start),
    .pipeline_busy    (pipeline_busy),
    .pipeline_stalled (pipeline_stalled),
    .pipeline_ready   (pipeline_ready),
    .frames_in        (frames_in),
    .frames_out       (frames_out),
    .layer_timeout    (layer_timeout),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] done;
    logic [9:0] l0, l1, f0, f1;
    logic [2:0] start;
    logic       busy, stall, ready;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame through layer i: admit, hold two RUN cycles, then done.
  task automatic run_frame(input int i);
    in_level[i*10 +: 10] = 10'(in_sz[i]);
    out_free[i*10 +: 10] = 10'(out_sz[i]);
    tick();
    check($sformatf("chain start L%0d", i), 32'(layer_start[i]), 1);
    in_level[i*10 +: 10] = '0;
    tick();
    check($sformatf("chain single pulse L%0d", i), 32'(layer_start[i]), 0);
    tick();
    layer_done[i] = 1'b1;
    tick();
    layer_done[i] = 1'b0;
    check($sformatf("chain idle L%0d", i), 32'(pipeline_busy), 0);
  endtask

  task automatic clear_pulse();
    pipeline_reset = 1'b1;
    tick();
    pipeline_reset = 1'b0;
  endtask

  initial begin
    // en, done, l0, l1, f0, f1 | start, busy, stall, ready
    tbl[0]  = '{1'b1, 3'b000, 10'd0, 10'd0,   10'd0,   10'd0,  3'b000, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 3'b000, 10'd5, 10'd0,   10'd200, 10'd0,  3'b000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 3'b000, 10'd6, 10'd0,   10'd200, 10'd0,  3'b001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'b000, 10'd6, 10'd0,   10'd200, 10'd0,  3'b000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'b001, 10'd0, 10'd0,   10'd200, 10'd0,  3'b000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 3'b000, 10'd0, 10'd100, 10'd200, 10'd49, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 10'd0, 10'd100, 10'd200, 10'd50, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'b000, 10'd0, 10'd100, 10'd200, 10'd49, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 10'd0, 10'd100, 10'd200, 10'd50, 3'b010, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'b010, 10'd0, 10'd100, 10'd200, 10'd50, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'b000, 10'd0, 10'd100, 10'd200, 10'd50, 3'b010, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'b000, 10'd0, 10'd0,   10'd200, 10'd50, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'b010, 10'd0, 10'd0,   10'd200, 10'd50, 3'b000, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 3'b000, 10'd6, 10'd100, 10'd200, 10'd50, 3'b011, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 3'b011, 10'd0, 10'd0,   10'd200, 10'd50, 3'b000, 1'b0, 1'b0, 1'b1};

    rst_n          = 1'b0;
    network_enable = 1'b1;
    pipeline_reset = 1'b0;
    layer_busy     = '0;
    layer_done     = '0;
    in_level       = '0;
    out_free       = '0;

    #12;
    check("rst start", 32'(layer_start), 0);
    check("rst frames_in", 32'(frames_in), 0);
    check("rst frames_out", 32'(frames_out), 0);
    check("rst timeout", 32'(layer_timeout), 0);
    check("rst perr", 32'(protocol_err), 0);
    check("rst busy", 32'(pipeline_busy), 0);
    check("rst ready", 32'(pipeline_ready), 1);
    rst_n = 1'b1;
    tick();
    check("idle ready", 32'(pipeline_ready), 1);
    check("idle stalled", 32'(pipeline_stalled), 0);

    for (int r = 0; r < 15; r++) begin
      network_enable = tbl[r].en;
      layer_done     = tbl[r].done;
      in_level       = {10'd0, tbl[r].l1, tbl[r].l0};
      out_free       = {10'd0, tbl[r].f1, tbl[r].f0};
      tick();
      check($sformatf("row%0d start", r), 32'(layer_start), 32'(tbl[r].start));
      check($sformatf("row%0d busy", r), 32'(pipeline_busy), 32'(tbl[r].busy));
      check($sformatf("row%0d stall", r), 32'(pipeline_stalled), 32'(tbl[r].stall));
      check($sformatf("row%0d ready", r), 32'(pipeline_ready), 32'(tbl[r].ready));
    end
    layer_done = '0;
    out_free   = '0;
    check("table frames_in", 32'(frames_in), 2);
    check("table frames_out", 32'(frames_out), 0);
    check("table perr", 32'(protocol_err), 0);

    // Three frames through the whole chain, then two more into layer 0 to wrap frames_in.
    clear_pulse();
    check("clear frames_in", 32'(frames_in), 0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) run_frame(i);
    end
    check("chain frames_in", 32'(frames_in), 3);
    check("chain frames_out", 32'(frames_out), 3);
    check("chain ready", 32'(pipeline_ready), 1);
    run_frame(0);
    run_frame(0);
    check("wrap frames_in", 32'(frames_in), 1);
    check("wrap frames_out", 32'(frames_out), 3);

    // Watchdog on layer 2: limit 8, flag visible 8 cycles after the START cycle.
    clear_pulse();
    out_free = '0;
    in_level = '0;
    in_level[29:20] = 10'd50;
    out_free[29:20] = 10'd3;
    tick();
    check("wd start", 32'(layer_start), 3'b100);
    in_level = '0;
    for (int n = 1; n < 8; n++) begin
      tick();
      check($sformatf("wd quiet c%0d", n), 32'(layer_timeout), 0);
    end
    tick();
    check("wd fire", 32'(layer_timeout), 3'b100);
    check("wd still run", 32'(pipeline_busy), 1);
    for (int n = 0; n < 3; n++) tick();
    check("wd sticky", 32'(layer_timeout), 3'b100);
    layer_done = 3'b100;
    tick();
    layer_done = '0;
    check("wd done idle", 32'(pipeline_busy), 0);
    check("wd frames_out", 32'(frames_out), 1);
    check("wd sticky after done", 32'(layer_timeout), 3'b100);

    check("perr before", 32'(protocol_err), 0);
    layer_done = 3'b010;
    tick();
    layer_done = '0;
    check("perr set", 32'(protocol_err), 1);
    check("perr no start", 32'(layer_start), 0);
    check("perr idle", 32'(pipeline_busy), 0);
    tick();
    check("perr sticky", 32'(protocol_err), 1);

    // Synchronous clear while every layer runs; coincident done is ignored.
    in_level = {10'd50, 10'd100, 10'd6};
    out_free = {10'd3, 10'd50, 10'd100};
    tick();
    check("all start", 32'(layer_start), 3'b111);
    in_level = '0;
    tick();
    check("all run", 32'(pipeline_busy), 1);
    check("all run frames_in", 32'(frames_in), 1);
    pipeline_reset = 1'b1;
    layer_done     = 3'b100;
    tick();
    layer_done = '0;
    check("clr busy", 32'(pipeline_busy), 0);
    check("clr start", 32'(layer_start), 0);
    check("clr frames_in", 32'(frames_in), 0);
    check("clr frames_out", 32'(frames_out), 0);
    check("clr timeout", 32'(layer_timeout), 0);
    check("clr perr", 32'(protocol_err), 0);
    in_level[9:0] = 10'd6;
    tick();
    check("clr blocks admit", 32'(layer_start), 0);
    check("clr blocks busy", 32'(pipeline_busy), 0);
    pipeline_reset = 1'b0;
    tick();
    check("post clr start", 32'(layer_start), 3'b001);
    tick();
    check("pre async frames_in", 32'(frames_in), 1);
    check("pre async busy", 32'(pipeline_busy), 1);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("async busy", 32'(pipeline_busy), 0);
    check("async frames_in", 32'(frames_in), 0);
    check("async start", 32'(layer_start), 0);
    in_level = '0;
    #2 rst_n = 1'b1;
    tick();
    check("after async busy", 32'(pipeline_busy), 0);
    check("after async ready", 32'(pipeline_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
